huffman_param: RTL and testbench
================================

Name: huffman_param

Overview:
- Parametrised Huffman engine for NSYM symbols:
  - counts symbol occurrences from one gray_valid burst;
  - reports the counts;
  - builds codes by iterative two-minimum merging, one merge per cycle;
  - outputs per-symbol codes and masks.
- Generalises the fixed 6-symbol flow in symbol count and widths.
- Adds zero-count exclusion, count saturation and back-to-back bursts.
- Sits between the pixel source and the bitstream packer.

Parameters:
- NSYM, 6, number of symbols; data value v in 1..NSYM maps to symbol v-1.
- DATA_W, 8, gray_data width.
- CNT_W, 8, per-symbol count width; counts saturate.
- CODE_W, 8, per-symbol code/mask width; must be >= NSYM-1 (elaboration error otherwise).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- gray_valid  in  1  qualifies gray_data; one burst = contiguous high cycles.
- gray_data  in  DATA_W  symbol value; values 0 or >NSYM are ignored (not counted).
- CNT_valid  out  1  one-cycle pulse: CNT holds final counts.
- CNT  out  NSYM*CNT_W  symbol k count at [k*CNT_W +: CNT_W].
- code_valid  out  1  one-cycle pulse: HC/M hold final codes.
- HC  out  NSYM*CODE_W  symbol k code, right-aligned, at [k*CODE_W +: CODE_W].
- M  out  NSYM*CODE_W  symbol k mask = (1<<len)-1; 0 for absent symbols.

Behaviour:
- Reset (any time, incl. mid-merge):
  - state IDLE; CNT, HC, M, all weights and group ids = 0; CNT_valid = code_valid = 0.
  - A pulse in flight is dropped.
- Registered outputs. HC/M change only at merge edges. CNT changes only in COUNT.
- FSM states: IDLE, COUNT, REPORT, MERGE, DONE.
- IDLE / DONE:
  - gray_valid=1 clears CNT/HC/M and counts the current byte (cleared value + 1).
  - Then -> COUNT.
- COUNT:
  - Each gray_valid=1 cycle with an in-range value increments that count; saturates at 2^CNT_W-1.
  - gray_valid=0 -> REPORT.
- REPORT:
  - CNT_valid=1 for this single cycle.
  - Initialise per symbol k: weight[k]=CNT[k], grp[k]=k, active[k]=(CNT[k]!=0); K = number of active groups.
  - K>=2 -> MERGE. K<=1 -> DONE.
  - K==1: the sole symbol gets HC=0, M=1.
  - K==0: HC=M=0 for all symbols.
  - code_valid=1 the cycle after REPORT.
- MERGE, one merge per clock:
  - Find active groups a (smallest weight) and b (second smallest).
  - Tie rule: equal weights -> the group with the higher representative index counts as smaller.
  - Every member symbol of a gets bit 1 at position len; every member of b gets bit 0; those symbols' len increments (M = M<<1|1).
  - Merged group takes rep = min(rep_a, rep_b) and weight = weight_a + weight_b.
  - Weight width = CNT_W + clog2(NSYM); no overflow.
  - Deactivate the other rep.
  - After K-1 merges -> DONE with code_valid=1 for one cycle.
- Latency:
  - CNT_valid is 1 cycle after the first gray_valid=0 of the burst.
  - code_valid is K cycles after CNT_valid for K>=2, 1 cycle for K<=1.
- gray_valid during REPORT/MERGE is ignored: no count, no restart.
- Codes are prefix-free. The longest code is <= NSYM-1 bits.

Decomposition:
- huffman_pkg:
  - state enum;
  - clog2 function;
  - localparam WGT_W = CNT_W + clog2(NSYM);
  - helper functions for packed-slice indexing.
- One sub-module, huffman_min2_find:
  - combinational;
  - inputs: weight vector, rep vector, active mask;
  - outputs: index a, index b, valid;
  - applies the tie rule.
- Group membership is stored as grp[k] (rep per symbol); member test is grp[k]==rep.

Test Plan:
- NSYM=6, burst 1,1,1,1,2,2,3,4 then gray_valid=0:
  - CNT_valid one cycle later with CNT1..6=4,2,1,1,0,0.
  - code_valid 4 cycles after CNT_valid with HC1..4=0,2,6,7, M1..4=1,3,7,7; HC5/6=M5/6=0.
- Burst of five 2s:
  - CNT2=5, others 0.
  - code_valid 1 cycle after CNT_valid; HC2=0, M2=1, all others 0.
- 300 bytes of symbol 1 plus bytes 0 and 9 interleaved:
  - CNT1=255 (saturated); 0 and 9 not counted.
  - HC1=0, M1=1.
- Reset low on the 2nd MERGE cycle:
  - all outputs 0 asynchronously; code_valid never asserts.
  - A new burst afterwards produces correct results.
- Second burst (3,3,5) started the cycle after code_valid:
  - counts cleared, then CNT3=2, CNT5=1.
  - code_valid 2 cycles after CNT_valid; HC3=0, M3=1, HC5=1, M5=1.
- gray_valid pulsed during MERGE:
  - counts and codes unchanged; code_valid timing unchanged.

Source files
------------

// File: rtl/huffman_pkg.sv
// huffman_pkg: shared FSM encoding, width helpers and packed-slice index
// helpers for the parametrised Huffman engine and its min-pair finder.
package huffman_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_REPORT,
        ST_MERGE,
        ST_DONE
    } state_e;

    localparam int DEF_NSYM  = 6;
    localparam int DEF_CNT_W = 8;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Merged weights never exceed NSYM * max count, so this width cannot wrap.
    function automatic int wgt_w(input int cnt_w, input int nsym);
        return cnt_w + clog2(nsym);
    endfunction

    // Symbol / group index width, at least one bit.
    function automatic int idx_w(input int nsym);
        return (nsym < 2) ? 1 : clog2(nsym);
    endfunction

    // Low bit of element k in a flat vector of w-bit elements.
    function automatic int lo(input int k, input int w);
        return k * w;
    endfunction

    localparam int WGT_W = DEF_CNT_W + clog2(DEF_NSYM);

endpackage

// File: rtl/huffman_min2_find.sv
// huffman_min2_find: combinational search for the two lightest active groups.
// Ports: wgt_i/rep_i/act_i per-slot weight, representative and active flag;
//        a_o = lightest slot, b_o = second lightest, valid_o = two found.
module huffman_min2_find
    import huffman_pkg::*;
#(
    parameter int NSYM = 6,
    parameter int WW   = 11,
    parameter int IW   = 3
) (
    input  logic [NSYM*WW-1:0] wgt_i,
    input  logic [NSYM*IW-1:0] rep_i,
    input  logic [NSYM-1:0]    act_i,
    output logic [IW-1:0]      a_o,
    output logic [IW-1:0]      b_o,
    output logic               valid_o
);

    logic [WW-1:0] w [NSYM];
    logic [IW-1:0] r [NSYM];
    int            ia;
    int            ib;
    logic          fa;
    logic          fb;

    for (genvar k = 0; k < NSYM; k++) begin : g_unpack
        assign w[k] = wgt_i[lo(k, WW) +: WW];
        assign r[k] = rep_i[lo(k, IW) +: IW];
    end

    // On equal weight the group with the higher representative is lighter.
    function automatic logic beats(
        input logic [WW-1:0] wx,
        input logic [IW-1:0] rx,
        input logic [WW-1:0] wy,
        input logic [IW-1:0] ry
    );
        return (wx < wy) || ((wx == wy) && (rx > ry));
    endfunction

    always_comb begin
        ia = 0;
        ib = 0;
        fa = 1'b0;
        fb = 1'b0;
        for (int k = 0; k < NSYM; k++) begin
            if (act_i[k] && (!fa || beats(w[k], r[k], w[ia], r[ia]))) begin
                ia = k;
                fa = 1'b1;
            end
        end
        for (int k = 0; k < NSYM; k++) begin
            if (act_i[k] && (k != ia) &&
                (!fb || beats(w[k], r[k], w[ib], r[ib]))) begin
                ib = k;
                fb = 1'b1;
            end
        end
    end

    assign a_o     = IW'(ia);
    assign b_o     = IW'(ib);
    assign valid_o = fa & fb;

endmodule

// File: rtl/huffman_param.sv
// huffman_param: counts symbols over one gray_valid burst, reports CNT, then
// builds Huffman codes HC / masks M by one two-minimum merge per clock.
// Ports: clk, reset (async active-low), gray_valid/gray_data burst input,
//        CNT_valid/CNT counts pulse, code_valid/HC/M codes pulse.
module huffman_param
    import huffman_pkg::*;
#(
    parameter int NSYM   = 6,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int CODE_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     gray_valid,
    input  logic [DATA_W-1:0]        gray_data,
    output logic                     CNT_valid,
    output logic [NSYM*CNT_W-1:0]    CNT,
    output logic                     code_valid,
    output logic [NSYM*CODE_W-1:0]   HC,
    output logic [NSYM*CODE_W-1:0]   M
);

    localparam int WW = wgt_w(CNT_W, NSYM);
    localparam int IW = idx_w(NSYM);

    if (CODE_W < NSYM - 1) begin : g_code_w_chk
        $error("huffman_param: CODE_W must be >= NSYM-1");
    end

    state_e                      state_q, state_d;
    logic [NSYM-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NSYM-1:0][CODE_W-1:0] hc_q, hc_d;
    logic [NSYM-1:0][CODE_W-1:0] m_q, m_d;
    logic [NSYM-1:0][WW-1:0]     wgt_q, wgt_d;
    logic [NSYM-1:0][IW-1:0]     grp_q, grp_d;
    logic [NSYM-1:0]             act_q, act_d;
    logic [IW:0]                 rem_q, rem_d;
    logic                        cnt_vld_q, cnt_vld_d;
    logic                        code_vld_q, code_vld_d;

    logic [NSYM-1:0]             hit;
    logic [NSYM-1:0][IW-1:0]     rep_id;
    logic [IW:0]                 n_act;
    logic [IW-1:0]               a_idx;
    logic [IW-1:0]               b_idx;
    logic [IW-1:0]               keep;
    logic [IW-1:0]               drop;
    logic                        pair_ok;

    // Group slot k is owned by representative k, so reps are the slot ids.
    for (genvar k = 0; k < NSYM; k++) begin : g_sym
        assign hit[k]    = (gray_data == DATA_W'(k + 1));
        assign rep_id[k] = IW'(k);
    end

    always_comb begin
        n_act = '0;
        for (int k = 0; k < NSYM; k++) begin
            n_act = n_act + (IW + 1)'(cnt_q[k] != '0);
        end
    end

    huffman_min2_find #(
        .NSYM (NSYM),
        .WW   (WW),
        .IW   (IW)
    ) u_min2 (
        .wgt_i   (wgt_q),
        .rep_i   (rep_id),
        .act_i   (act_q),
        .a_o     (a_idx),
        .b_o     (b_idx),
        .valid_o (pair_ok)
    );

    assign keep = (a_idx < b_idx) ? a_idx : b_idx;
    assign drop = (a_idx < b_idx) ? b_idx : a_idx;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hc_d       = hc_q;
        m_d        = m_q;
        wgt_d      = wgt_q;
        grp_d      = grp_q;
        act_d      = act_q;
        rem_d      = rem_q;
        cnt_vld_d  = 1'b0;
        code_vld_d = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (gray_valid) begin
                    cnt_d = '0;
                    hc_d  = '0;
                    m_d   = '0;
                    for (int k = 0; k < NSYM; k++) begin
                        if (hit[k]) cnt_d[k] = CNT_W'(1);
                    end
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (gray_valid) begin
                    for (int k = 0; k < NSYM; k++) begin
                        if (hit[k] && (cnt_q[k] != '1)) begin
                            cnt_d[k] = cnt_q[k] + CNT_W'(1);
                        end
                    end
                end else begin
                    state_d   = ST_REPORT;
                    cnt_vld_d = 1'b1;
                end
            end
            ST_REPORT: begin
                for (int k = 0; k < NSYM; k++) begin
                    wgt_d[k] = WW'(cnt_q[k]);
                    grp_d[k] = IW'(k);
                    act_d[k] = (cnt_q[k] != '0);
                end
                rem_d = n_act;
                if (n_act >= (IW + 1)'(2)) begin
                    state_d = ST_MERGE;
                end else begin
                    // Zero or one symbol: codes are final right away.
                    state_d    = ST_DONE;
                    code_vld_d = 1'b1;
                    for (int k = 0; k < NSYM; k++) begin
                        hc_d[k] = '0;
                        m_d[k]  = act_d[k] ? CODE_W'(1) : '0;
                    end
                end
            end
            ST_MERGE: begin
                if (pair_ok) begin
                    // M+1 is the bit at the current code length.
                    for (int k = 0; k < NSYM; k++) begin
                        if (grp_q[k] == a_idx) begin
                            hc_d[k]  = hc_q[k] | (m_q[k] + CODE_W'(1));
                            m_d[k]   = (m_q[k] << 1) | CODE_W'(1);
                            grp_d[k] = keep;
                        end else if (grp_q[k] == b_idx) begin
                            m_d[k]   = (m_q[k] << 1) | CODE_W'(1);
                            grp_d[k] = keep;
                        end
                    end
                    wgt_d[keep] = wgt_q[a_idx] + wgt_q[b_idx];
                    wgt_d[drop] = '0;
                    act_d[drop] = 1'b0;
                    rem_d       = rem_q - (IW + 1)'(1);
                    if (rem_q <= (IW + 1)'(2)) begin
                        state_d    = ST_DONE;
                        code_vld_d = 1'b1;
                    end
                end else begin
                    state_d    = ST_DONE;
                    code_vld_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hc_q       <= '0;
            m_q        <= '0;
            wgt_q      <= '0;
            grp_q      <= '0;
            act_q      <= '0;
            rem_q      <= '0;
            cnt_vld_q  <= 1'b0;
            code_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hc_q       <= hc_d;
            m_q        <= m_d;
            wgt_q      <= wgt_d;
            grp_q      <= grp_d;
            act_q      <= act_d;
            rem_q      <= rem_d;
            cnt_vld_q  <= cnt_vld_d;
            code_vld_q <= code_vld_d;
        end
    end

    assign CNT_valid  = cnt_vld_q;
    assign CNT        = cnt_q;
    assign code_valid = code_vld_q;
    assign HC         = hc_q;
    assign M          = m_q;

endmodule

// File: tb/tb_huffman_param.sv
// tb_huffman_param: directed scenario bench for huffman_param (NSYM=6,
// 8-bit counts and codes); each task drives one scenario and checks inline.
module tb_huffman_param;

    logic        clk;
    logic        reset;
    logic        gv;
    logic [7:0]  gd;
    logic        CNT_valid;
    logic [47:0] CNT;
    logic        code_valid;
    logic [47:0] HC;
    logic [47:0] M;

    int checks = 0;
    int passes = 0;

    huffman_param #(
        .NSYM   (6),
        .DATA_W (8),
        .CNT_W  (8),
        .CODE_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_valid (gv),
        .gray_data  (gd),
        .CNT_valid  (CNT_valid),
        .CNT        (CNT),
        .code_valid (code_valid),
        .HC         (HC),
        .M          (M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_byte(input logic [7:0] v);
        @(negedge clk);
        gv = 1'b1;
        gd = v;
    endtask

    task automatic end_burst();
        @(negedge clk);
        gv = 1'b0;
        gd = 8'd0;
    endtask

    // Cycles from the CNT_valid sample to the code_valid sample; -1 on timeout.
    task automatic wait_code(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (code_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (CNT_valid !== 1'b0 || code_valid !== 1'b0)
            $display("FAIL reset_vld: got %b%b want 00", CNT_valid, code_valid);
        else passes++;
        checks++;
        if (CNT !== 48'd0) $display("FAIL reset_cnt: got %h want 0", CNT);
        else passes++;
        checks++;
        if (HC !== 48'd0 || M !== 48'd0)
            $display("FAIL reset_code: got %h/%h want 0/0", HC, M);
        else passes++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n;
        byte unsigned seq[8] = '{1, 1, 1, 1, 2, 2, 3, 4};
        logic [47:0] e_cnt = {8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd4};
        logic [47:0] e_hc  = {8'd0, 8'd0, 8'd7, 8'd6, 8'd2, 8'd0};
        logic [47:0] e_m   = {8'd0, 8'd0, 8'd7, 8'd7, 8'd3, 8'd1};
        foreach (seq[i]) drive_byte(seq[i]);
        end_burst();
        @(negedge clk);
        checks++;
        if (CNT_valid !== 1'b1) $display("FAIL basic_cvld: got %b want 1", CNT_valid);
        else passes++;
        checks++;
        if (CNT !== e_cnt) $display("FAIL basic_cnt: got %h want %h", CNT, e_cnt);
        else passes++;
        wait_code(n);
        checks++;
        if (n !== 4) $display("FAIL basic_lat: got %0d want 4", n);
        else passes++;
        checks++;
        if (HC !== e_hc) $display("FAIL basic_hc: got %h want %h", HC, e_hc);
        else passes++;
        checks++;
        if (M !== e_m) $display("FAIL basic_m: got %h want %h", M, e_m);
        else passes++;
        @(negedge clk);
        checks++;
        if (code_valid !== 1'b0) $display("FAIL basic_pulse: got %b want 0", code_valid);
        else passes++;
    endtask

    task automatic test_single();
        int n;
        logic [47:0] e_cnt = {32'd0, 8'd5, 8'd0};
        logic [47:0] e_m   = {32'd0, 8'd1, 8'd0};
        repeat (5) drive_byte(8'd2);
        end_burst();
        @(negedge clk);
        checks++;
        if (CNT_valid !== 1'b1 || CNT !== e_cnt)
            $display("FAIL single_cnt: got %b/%h want 1/%h", CNT_valid, CNT, e_cnt);
        else passes++;
        checks++;
        if (HC !== 48'd0 || M !== 48'd0)
            $display("FAIL single_clear: got %h/%h want 0/0", HC, M);
        else passes++;
        wait_code(n);
        checks++;
        if (n !== 1) $display("FAIL single_lat: got %0d want 1", n);
        else passes++;
        checks++;
        if (HC !== 48'd0 || M !== e_m)
            $display("FAIL single_code: got %h/%h want 0/%h", HC, M, e_m);
        else passes++;
    endtask

    task automatic test_saturate();
        int n;
        logic [47:0] e_cnt = {40'd0, 8'd255};
        logic [47:0] e_m   = {40'd0, 8'd1};
        for (int i = 0; i < 300; i++) begin
            drive_byte(8'd1);
            if (i % 50 == 0) begin
                drive_byte(8'd0);
                drive_byte(8'd9);
            end
        end
        end_burst();
        @(negedge clk);
        checks++;
        if (CNT !== e_cnt) $display("FAIL sat_cnt: got %h want %h", CNT, e_cnt);
        else passes++;
        wait_code(n);
        checks++;
        if (n !== 1) $display("FAIL sat_lat: got %0d want 1", n);
        else passes++;
        checks++;
        if (HC !== 48'd0 || M !== e_m)
            $display("FAIL sat_code: got %h/%h want 0/%h", HC, M, e_m);
        else passes++;
    endtask

    task automatic test_reset_mid_merge();
        int n;
        int seen;
        byte unsigned seq[8] = '{1, 1, 1, 1, 2, 2, 3, 4};
        logic [47:0] e_cnt = {32'd0, 8'd3, 8'd1};
        logic [47:0] e_hc  = {40'd0, 8'd1};
        logic [47:0] e_m   = {32'd0, 8'd1, 8'd1};
        foreach (seq[i]) drive_byte(seq[i]);
        end_burst();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (CNT !== 48'd0 || HC !== 48'd0 || M !== 48'd0)
            $display("FAIL rstm_clear: got %h/%h/%h want 0", CNT, HC, M);
        else passes++;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (code_valid !== 1'b0 || CNT_valid !== 1'b0) seen++;
        end
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (code_valid !== 1'b0 || CNT_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL rstm_pulse: got %0d pulses want 0", seen);
        else passes++;
        drive_byte(8'd2);
        drive_byte(8'd2);
        drive_byte(8'd2);
        drive_byte(8'd1);
        end_burst();
        @(negedge clk);
        checks++;
        if (CNT_valid !== 1'b1 || CNT !== e_cnt)
            $display("FAIL rstm_cnt: got %b/%h want 1/%h", CNT_valid, CNT, e_cnt);
        else passes++;
        wait_code(n);
        checks++;
        if (n !== 2) $display("FAIL rstm_lat: got %0d want 2", n);
        else passes++;
        checks++;
        if (HC !== e_hc || M !== e_m)
            $display("FAIL rstm_code: got %h/%h want %h/%h", HC, M, e_hc, e_m);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int n;
        logic [47:0] e_hc1  = {8'd1, 40'd0};
        logic [47:0] e_m1   = {8'd1, 8'd1, 32'd0};
        logic [47:0] e_mid  = {24'd0, 8'd1, 16'd0};
        logic [47:0] e_cnt  = {8'd0, 8'd1, 8'd0, 8'd2, 16'd0};
        logic [47:0] e_hc2  = {8'd0, 8'd1, 32'd0};
        logic [47:0] e_m2   = {8'd0, 8'd1, 8'd0, 8'd1, 16'd0};
        drive_byte(8'd5);
        drive_byte(8'd5);
        drive_byte(8'd6);
        end_burst();
        @(negedge clk);
        wait_code(n);
        checks++;
        if (n !== 2 || HC !== e_hc1 || M !== e_m1)
            $display("FAIL b2b_first: got %0d %h/%h want 2 %h/%h", n, HC, M, e_hc1, e_m1);
        else passes++;
        drive_byte(8'd3);
        @(negedge clk);
        checks++;
        if (CNT !== e_mid || HC !== 48'd0)
            $display("FAIL b2b_clear: got %h/%h want %h/0", CNT, HC, e_mid);
        else passes++;
        gv = 1'b1;
        gd = 8'd3;
        drive_byte(8'd5);
        end_burst();
        @(negedge clk);
        checks++;
        if (CNT_valid !== 1'b1 || CNT !== e_cnt)
            $display("FAIL b2b_cnt: got %b/%h want 1/%h", CNT_valid, CNT, e_cnt);
        else passes++;
        wait_code(n);
        checks++;
        if (n !== 2) $display("FAIL b2b_lat: got %0d want 2", n);
        else passes++;
        checks++;
        if (HC !== e_hc2 || M !== e_m2)
            $display("FAIL b2b_code: got %h/%h want %h/%h", HC, M, e_hc2, e_m2);
        else passes++;
    endtask

    task automatic test_merge_ignore();
        int n;
        int extra;
        byte unsigned seq[8] = '{1, 1, 1, 1, 2, 2, 3, 4};
        logic [47:0] e_cnt = {8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd4};
        logic [47:0] e_hc  = {8'd0, 8'd0, 8'd7, 8'd6, 8'd2, 8'd0};
        logic [47:0] e_m   = {8'd0, 8'd0, 8'd7, 8'd7, 8'd3, 8'd1};
        foreach (seq[i]) drive_byte(seq[i]);
        end_burst();
        @(negedge clk);
        n = -1;
        extra = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            gv = (i == 1 || i == 2);
            gd = 8'd5;
            if (CNT_valid !== 1'b0) extra++;
            if (code_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        gv = 1'b0;
        gd = 8'd0;
        checks++;
        if (n !== 4) $display("FAIL mign_lat: got %0d want 4", n);
        else passes++;
        checks++;
        if (HC !== e_hc || M !== e_m)
            $display("FAIL mign_code: got %h/%h want %h/%h", HC, M, e_hc, e_m);
        else passes++;
        repeat (3) begin
            @(negedge clk);
            if (CNT_valid !== 1'b0) extra++;
        end
        checks++;
        if (CNT !== e_cnt || extra !== 0)
            $display("FAIL mign_cnt: got %h extra=%0d want %h extra=0", CNT, extra, e_cnt);
        else passes++;
    endtask

    initial begin
        reset = 1'b0;
        gv    = 1'b0;
        gd    = 8'd0;
        test_reset();
        test_basic();
        test_single();
        test_saturate();
        test_reset_mid_merge();
        test_back_to_back();
        test_merge_ignore();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
